name_packer: RTL and testbench
==============================

NAME_PACKER -- requirements
Module: name_packer

Interface
REQ-001 SEP, default 8'h2F, name component separator byte ('/').
REQ-002 CHUNK_BYTES, default 8, maximum bytes per output chunk; fixed at 8 to match the 64-bit hash data input.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_byte  input  8  next byte of the NDN name stream.
REQ-006 in_valid  input  1  in_byte, in_last are valid.
REQ-007 in_last  input  1  in_byte is the final byte of the current name.
REQ-008 in_ready  output  1  block can accept a byte this cycle.
REQ-009 data  output  64  packed chunk; first byte in data[7:0]; unused bytes zero.
REQ-010 len  output  6  valid byte count of data (0..8).
REQ-011 out_valid  output  1  data, len, comp_end, name_end are valid.
REQ-012 out_ready  input  1  downstream hash stage accepts the chunk.
REQ-013 comp_end  output  1  chunk closes a name component; 0 when split at the 8-byte boundary.
REQ-014 name_end  output  1  chunk is the last chunk of the name.

Function
REQ-015 A byte SHALL be accepted only in a cycle with in_valid=1 and in_ready=1; in_ready SHALL be the inverse of out_valid.
REQ-016 A chunk SHALL be transferred in a cycle with out_valid=1 and out_ready=1; out_valid, data, len, comp_end and name_end SHALL hold stable until that transfer.
REQ-017 An accepted byte not equal to SEP SHALL be written at byte lane `count` of the accumulation register, and `count` SHALL increment.
REQ-018 When an accepted non-SEP byte brings `count` to 8 without in_last, a chunk SHALL be emitted with len=8, comp_end=0, name_end=0.
REQ-019 An accepted SEP with count>0 SHALL emit the accumulated chunk with comp_end=1 and name_end=in_last.
REQ-020 An accepted SEP with count=0 and in_last=0 SHALL be discarded without output (leading or repeated separators).
REQ-021 An accepted SEP with count=0 and in_last=1 SHALL emit a chunk with len=0, data=0, comp_end=0, name_end=1.
REQ-022 An accepted non-SEP byte with in_last=1 SHALL emit the chunk including that byte, with comp_end=1 and name_end=1, including when `count` reaches 8 in that cycle.
REQ-023 Emit latency SHALL be one cycle: out_valid rises on the clock edge that accepts the closing byte.
REQ-024 On emit, the accumulation register SHALL clear to zero and `count` SHALL reset to 0, so the next chunk starts in lane 0.
REQ-025 State machine SHALL be COLLECT (in_ready=1) -> EMIT on any emit condition, and EMIT (out_valid=1) -> COLLECT on the out_ready handshake.
REQ-026 No byte SHALL be accepted in the cycle a chunk transfers; in_ready rises the following cycle, giving a maximum throughput of one chunk per two cycles at the chunk boundary.
REQ-027 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-028 While rst=1, asynchronously: out_valid=0, data=0, len=0, comp_end=0, name_end=0, count=0, accumulation register=0, state=COLLECT; in_ready SHALL be 1 once rst deasserts.
REQ-029 Assertion of rst mid-name or while a chunk is pending SHALL discard all partial and pending data; no chunk SHALL be emitted for it after reset.

Verification
REQ-030 Stream 2F,61,62,2F,63(last), out_ready=1 -> chunk1 data=64'h6261 len=2 comp_end=1 name_end=0; chunk2 data=64'h63 len=1 comp_end=1 name_end=1.
REQ-031 Stream 2F, then bytes 01..0A (last on 0A) -> chunk1 data=64'h0807060504030201 len=8 comp_end=0 name_end=0; chunk2 data=64'h0A09 len=2 comp_end=1 name_end=1.
REQ-032 Stream 2F,2F,41,2F,2F(last) -> chunk1 data=64'h41 len=1 comp_end=1 name_end=0; chunk2 len=0 data=0 comp_end=0 name_end=1.
REQ-033 Backpressure: out_ready=0 for 5 cycles after chunk1 -> in_ready=0 and outputs stable for all 5 cycles; single transfer when out_ready=1; in_ready=1 the next cycle.
REQ-034 rst pulsed after 3 bytes of a component -> all outputs 0 immediately; subsequent stream 2F,5A(last) -> single chunk data=64'h5A len=1 comp_end=1 name_end=1.

Source files
------------

// File: rtl/name_packer.sv
// name_packer: splits an NDN name byte stream into hash-sized chunks.
// Bytes of a component are packed little-endian (first byte in lane 0) into
// an accumulation register; a chunk is emitted when a component closes, when
// the register fills, or when the name ends. Separators never appear in data.
//
// Handshake semantics (both ports): a transfer happens in a cycle where
// valid=1 and ready=1 at the rising edge of clk. The producer holds valid and
// its payload stable until that transfer; ready may change freely. Here
// in_ready is the inverse of out_valid, so the packer never accepts a byte in
// the cycle a chunk leaves, and out_ready is ignored while out_valid=0.
module name_packer #(
    parameter logic [7:0] SEP         = 8'h2F,
    parameter int         CHUNK_BYTES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_byte,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [CHUNK_BYTES*8-1:0] data,
    output logic [5:0]               len,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     comp_end,
    output logic                     name_end,
    output logic [0:0]               dbg_state,
    output logic [$clog2(CHUNK_BYTES+1)-1:0] dbg_count
);

    localparam int DW = CHUNK_BYTES * 8;
    localparam int CW = $clog2(CHUNK_BYTES + 1);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_EMIT    = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] count;
    logic [DW-1:0] acc;

    logic          accept;
    logic          is_sep;
    logic [CW-1:0] count_inc;
    logic [DW-1:0] acc_ins;

    logic          emit;
    logic [DW-1:0] emit_data;
    logic [5:0]    emit_len;
    logic          emit_comp_end;
    logic          emit_name_end;

    assign accept    = in_valid && (state == ST_COLLECT);
    assign is_sep    = (in_byte == SEP);
    assign count_inc = count + 1'b1;

    // Accumulator with the incoming byte placed at lane `count`.
    always_comb begin
        acc_ins = acc;
        for (int i = 0; i < CHUNK_BYTES; i++) begin
            if (count == CW'(i)) begin
                acc_ins[i*8 +: 8] = in_byte;
            end
        end
    end

    // Decide whether the accepted byte closes a chunk, and what that chunk is.
    always_comb begin
        emit          = 1'b0;
        emit_data     = '0;
        emit_len      = '0;
        emit_comp_end = 1'b0;
        emit_name_end = 1'b0;
        if (accept) begin
            if (!is_sep) begin
                // Data byte: close on name end or when the register fills.
                if (in_last || (count_inc == CW'(CHUNK_BYTES))) begin
                    emit          = 1'b1;
                    emit_data     = acc_ins;
                    emit_len      = 6'(count_inc);
                    emit_comp_end = in_last;
                    emit_name_end = in_last;
                end
            end else if (count != '0) begin
                // Separator after data: close the component.
                emit          = 1'b1;
                emit_data     = acc;
                emit_len      = 6'(count);
                emit_comp_end = 1'b1;
                emit_name_end = in_last;
            end else if (in_last) begin
                // Trailing separator with nothing pending: empty end-of-name marker.
                emit          = 1'b1;
                emit_name_end = 1'b1;
            end
            // Leading or repeated separator without in_last: dropped.
        end
    end

    // Accumulation register and byte count; cleared whenever a chunk is emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
        end else if (accept) begin
            if (emit) begin
                acc   <= '0;
                count <= '0;
            end else if (!is_sep) begin
                acc   <= acc_ins;
                count <= count_inc;
            end
        end
    end

    // COLLECT/EMIT state machine with registered chunk outputs held until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_COLLECT;
            data     <= '0;
            len      <= '0;
            comp_end <= 1'b0;
            name_end <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (emit) begin
                        state    <= ST_EMIT;
                        data     <= emit_data;
                        len      <= emit_len;
                        comp_end <= emit_comp_end;
                        name_end <= emit_name_end;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        state    <= ST_COLLECT;
                        data     <= '0;
                        len      <= '0;
                        comp_end <= 1'b0;
                        name_end <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_COLLECT;
                end
            endcase
        end
    end

    assign out_valid = (state == ST_EMIT);
    assign in_ready  = (state == ST_COLLECT);
    assign dbg_state = state;
    assign dbg_count = count;

endmodule

// File: tb/tb_name_packer.sv
// tb_name_packer: directed name streams plus a randomized stream, checked by
// an expected-chunk queue that is compared on every output transfer.
`timescale 1ns/1ps
module tb_name_packer;

    localparam int W = 64 + 6 + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [63:0] data;
    logic [5:0]  len;
    logic        out_valid;
    logic        out_ready;
    logic        comp_end;
    logic        name_end;
    logic [0:0]  dbg_state;
    logic [3:0]  dbg_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_q[$];
    logic [7:0]   m_buf[$];

    name_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .data      (data),
        .len       (len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .comp_end  (comp_end),
        .name_end  (name_end),
        .dbg_state (dbg_state),
        .dbg_count (dbg_count)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard: every output transfer is matched against the expected queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_chunk got data=%h len=%0d ce=%0b ne=%0b, expected no chunk",
                         data, len, comp_end, name_end);
            end else begin
                logic [W-1:0] exp;
                exp = exp_q.pop_front();
                if ({data, len, comp_end, name_end} !== exp) begin
                    $display("FAIL sb_chunk got data=%h len=%0d ce=%0b ne=%0b, expected data=%h len=%0d ce=%0b ne=%0b",
                             data, len, comp_end, name_end, exp[71:8], exp[7:2], exp[1], exp[0]);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] chunk(input logic [63:0] d, input int l,
                                           input logic ce, input logic ne);
        return {d, 6'(l), ce, ne};
    endfunction

    // Driver: present one byte and hold it until the packer accepts it.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int waited;
        waited   = 0;
        in_byte  = b;
        in_last  = last;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) begin
                n_checks++;
                $display("FAIL send_timeout byte=%h in_ready stayed %0b, expected 1", b, in_ready);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Reference model for the random stream: called once per accepted byte.
    task automatic model_byte(input logic [7:0] b, input logic last);
        logic [63:0] d;
        if (b != 8'h2F) begin
            m_buf.push_back(b);
            if (last || m_buf.size() == 8) begin
                d = '0;
                foreach (m_buf[i]) d[i*8 +: 8] = m_buf[i];
                exp_q.push_back(chunk(d, m_buf.size(), last, last));
                m_buf.delete();
            end
        end else if (m_buf.size() > 0) begin
            d = '0;
            foreach (m_buf[i]) d[i*8 +: 8] = m_buf[i];
            exp_q.push_back(chunk(d, m_buf.size(), 1'b1, last));
            m_buf.delete();
        end else if (last) begin
            exp_q.push_back(chunk(64'd0, 0, 1'b0, 1'b1));
        end
    endtask

    // Wait (bounded) until all expected chunks have been delivered.
    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_byte   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b, expected 0", out_valid);
        else n_pass++;
        n_checks++;
        if ({data, len, comp_end, name_end} !== {W{1'b0}})
            $display("FAIL reset_outputs got data=%h len=%0d ce=%0b ne=%0b, expected all 0", data, len, comp_end, name_end);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b, expected 1", in_ready);
        else n_pass++;
        n_checks++;
        if (dbg_state !== 1'b0 || dbg_count !== 4'd0)
            $display("FAIL reset_state got state=%0d count=%0d, expected 0/0", dbg_state, dbg_count);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        exp_q.push_back(chunk(64'h6261, 2, 1'b1, 1'b0));
        exp_q.push_back(chunk(64'h63, 1, 1'b1, 1'b1));
        send_byte(8'h2F, 1'b0);
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h2F, 1'b0);
        send_byte(8'h63, 1'b1);
        wait_idle();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL basic_drain got %0d pending, expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_split();
        exp_q.push_back(chunk(64'h0807060504030201, 8, 1'b0, 1'b0));
        exp_q.push_back(chunk(64'h0A09, 2, 1'b1, 1'b1));
        send_byte(8'h2F, 1'b0);
        for (int i = 1; i <= 10; i++) send_byte(8'(i), i == 10);
        wait_idle();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL split_drain got %0d pending, expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_separators();
        exp_q.push_back(chunk(64'h41, 1, 1'b1, 1'b0));
        exp_q.push_back(chunk(64'h0, 0, 1'b0, 1'b1));
        send_byte(8'h2F, 1'b0);
        send_byte(8'h2F, 1'b0);
        send_byte(8'h41, 1'b0);
        send_byte(8'h2F, 1'b0);
        send_byte(8'h2F, 1'b1);
        wait_idle();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL sep_drain got %0d pending, expected 0", exp_q.size());
        else n_pass++;
    endtask

    // Full 8-byte components with in_last on the filling byte, streamed back to back.
    task automatic test_back_to_back();
        exp_q.push_back(chunk(64'h1817161514131211, 8, 1'b1, 1'b1));
        exp_q.push_back(chunk(64'h2827262524232221, 8, 1'b0, 1'b0));
        exp_q.push_back(chunk(64'h3837363534333231, 8, 1'b1, 1'b1));
        for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i), i == 7);
        for (int i = 0; i < 8; i++) send_byte(8'h21 + 8'(i), 1'b0);
        for (int i = 0; i < 8; i++) send_byte(8'h31 + 8'(i), i == 7);
        wait_idle();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL b2b_drain got %0d pending, expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        exp_q.push_back(chunk(64'h6261, 2, 1'b1, 1'b0));
        exp_q.push_back(chunk(64'h63, 1, 1'b1, 1'b1));
        out_ready = 1'b0;
        send_byte(8'h2F, 1'b0);
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h2F, 1'b0);
        // Offer the next byte while stalled; it must not be taken.
        in_byte  = 8'h63;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL bp_stall cycle %0d got out_valid=%0b in_ready=%0b, expected 1/0", c, out_valid, in_ready);
            else n_pass++;
            n_checks++;
            if ({data, len, comp_end, name_end} !== chunk(64'h6261, 2, 1'b1, 1'b0))
                $display("FAIL bp_hold cycle %0d got data=%h len=%0d ce=%0b ne=%0b, expected data=6261 len=2 ce=1 ne=0",
                         c, data, len, comp_end, name_end);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release got out_valid=%0b in_ready=%0b, expected 0/1", out_valid, in_ready);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 1) $display("FAIL bp_single_transfer got %0d pending, expected 1", exp_q.size());
        else n_pass++;
        send_byte(8'h63, 1'b1);
        wait_idle();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL bp_drain got %0d pending, expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        // Pending chunk discarded by reset.
        out_ready = 1'b0;
        send_byte(8'h2F, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h2F, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || {data, len, comp_end, name_end} !== {W{1'b0}})
            $display("FAIL rst_pending got out_valid=%0b data=%h len=%0d, expected all 0", out_valid, data, len);
        else n_pass++;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        // Partial component discarded by reset.
        send_byte(8'h2F, 1'b0);
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h43, 1'b0);
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || {data, len, comp_end, name_end} !== {W{1'b0}} || dbg_count !== 4'd0)
            $display("FAIL rst_partial got out_valid=%0b data=%h len=%0d count=%0d, expected all 0",
                     out_valid, data, len, dbg_count);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(chunk(64'h5A, 1, 1'b1, 1'b1));
        send_byte(8'h2F, 1'b0);
        send_byte(8'h5A, 1'b1);
        wait_idle();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL rst_after_drain got %0d pending, expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_random();
        bit done;
        done = 1'b0;
        m_buf.delete();
        fork
            begin
                for (int n = 0; n < 6; n++) begin
                    int nlen;
                    nlen = $urandom_range(1, 24);
                    for (int k = 0; k < nlen; k++) begin
                        logic [7:0] b;
                        logic       last;
                        b    = ($urandom_range(0, 3) == 0) ? 8'h2F : 8'($urandom_range(1, 254));
                        last = (k == nlen - 1);
                        send_byte(b, last);
                        model_byte(b, last);
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_idle();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL random_drain got %0d pending, expected 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_split();
        test_separators();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
